// File: rtl/imm_pkg.sv
// Shared constants for the immediate-generator pipeline: RV32 base opcodes,
// the format codes reported on fmt, and the result FIFO depth.
package imm_pkg;

  localparam int FIFO_DEPTH = 2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // funct3 values of OP-IMM that carry a shift amount instead of an immediate
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Purely combinational immediate extraction for one RV32 instruction word.
// All immediates are sign-extended from instr[31]; shift amounts are
// zero-extended and widen to 6 bits when XLEN is 64.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic signed [11:0] i_imm, s_imm;
  logic signed [12:0] b_imm;
  logic signed [31:0] u_imm;
  logic signed [20:0] j_imm;

  assign opc   = instruction[6:0];
  assign f3    = instruction[14:12];
  assign i_imm = instruction[31:20];
  assign s_imm = {instruction[31:25], instruction[11:7]};
  assign b_imm = {instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
  assign u_imm = {instruction[31:12], 12'b0};
  assign j_imm = {instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};

  // Opcode-driven format select and immediate assembly
  always_comb begin
    imm     = '0;
    fmt     = FMT_R;
    illegal = 1'b0;
    case (opc)
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt = FMT_I;
        imm = XLEN'(i_imm);
      end
      OP_IMM: begin
        if (f3 == F3_SLLI || f3 == F3_SRXI) begin
          fmt = FMT_SHAMT;
          if (XLEN > 32) imm[5:0] = instruction[25:20];
          else           imm[4:0] = instruction[24:20];
        end else begin
          fmt = FMT_I;
          imm = XLEN'(i_imm);
        end
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = XLEN'(s_imm);
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        imm = XLEN'(b_imm);
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        imm = XLEN'(u_imm);
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = XLEN'(j_imm);
      end
      OP_OP: fmt = FMT_R;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a 2-entry result skid FIFO. Decode happens at the
// input; the FIFO isolates in_ready from out_ready so the block can run at
// full rate while tolerating one cycle of consumer backpressure.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } ent_t;

  localparam logic [1:0] OCC_FULL = 2'(FIFO_DEPTH);

  ent_t       dec;
  ent_t       mem [FIFO_DEPTH];
  ent_t       head;
  logic       wptr, rptr;
  logic [1:0] occ;
  logic       push, pop;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instruction (instruction),
    .imm         (dec.imm),
    .fmt         (dec.fmt),
    .illegal     (dec.ill)
  );

  // rst_n gates in_ready so nothing is accepted while reset is held
  assign in_ready  = rst_n && (occ != OCC_FULL);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rptr];

  // Head entry drives the outputs; idle outputs are forced to zero
  assign ImmExt  = out_valid ? head.imm : '0;
  assign fmt     = out_valid ? head.fmt : 3'd0;
  assign illegal = out_valid ? head.ill : 1'b0;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= 1'b0;
      rptr <= 1'b0;
      occ  <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Entry storage, written at the write pointer on push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= dec;
    end
  end

  // Saturating count of accepted illegal instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               illegal_cnt <= '0;
    else if (push && dec.ill && !(&illegal_cnt)) illegal_cnt <= illegal_cnt + 1'b1;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share stimulus,
// with a scoreboard of expected results built from hand-decoded constants.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instruction;
  logic        out_ready;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [3:0]  cnt32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [3:0]  cnt64;

  typedef struct {
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          n_asrt = 0;
  int          n_fail = 0;
  int          mcnt   = 0;
  logic        stall_prev = 1'b0;
  logic [35:0] prev32;
  logic [31:0] tbl [14];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .instruction(instruction), .out_valid(ov32), .out_ready(out_ready),
    .ImmExt(imm32), .fmt(fmt32), .illegal(ill32), .illegal_cnt(cnt32));

  imm_gen_pipe #(.XLEN(64), .CNT_W(4)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .instruction(instruction), .out_valid(ov64), .out_ready(out_ready),
    .ImmExt(imm64), .fmt(fmt64), .illegal(ill64), .illegal_cnt(cnt64));

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  // Hand-decoded expectations for every instruction the bench drives
  function automatic exp_t exp_of(input logic [31:0] ins);
    exp_t e;
    e.ill = 1'b0;
    case (ins)
      32'hFFC52283: begin e.imm64 = 64'hFFFFFFFFFFFFFFFC; e.fmt = 3'd1; end
      32'hFE000EE3: begin e.imm64 = 64'hFFFFFFFFFFFFFFFC; e.fmt = 3'd3; end
      32'h7FFFF06F: begin e.imm64 = 64'h00000000000FFFFE; e.fmt = 3'd5; end
      32'h8000006F: begin e.imm64 = 64'hFFFFFFFFFFF00000; e.fmt = 3'd5; end
      32'h00311093: begin e.imm64 = 64'h3;                e.fmt = 3'd6; end
      32'h0230D093: begin e.imm64 = 64'h23;               e.fmt = 3'd6; end
      32'h123450B7: begin e.imm64 = 64'h12345000;         e.fmt = 3'd4; end
      32'h800000B7: begin e.imm64 = 64'hFFFFFFFF80000000; e.fmt = 3'd4; end
      32'h00001017: begin e.imm64 = 64'h1000;             e.fmt = 3'd4; end
      32'hFE552C23: begin e.imm64 = 64'hFFFFFFFFFFFFFFF8; e.fmt = 3'd2; end
      32'h00B50533: begin e.imm64 = 64'h0;                e.fmt = 3'd0; end
      32'hFFF00067: begin e.imm64 = 64'hFFFFFFFFFFFFFFFF; e.fmt = 3'd1; end
      32'h00000073: begin e.imm64 = 64'h0;                e.fmt = 3'd1; end
      default:      begin e.imm64 = 64'h0;                e.fmt = 3'd0; e.ill = 1'b1; end
    endcase
    e.imm32 = e.imm64[31:0];
    if (ins == 32'h0230D093) e.imm32 = 32'h3;
    return e;
  endfunction

  // Sample just after the negedge drive; pop before push to match FIFO order
  task automatic sample();
    exp_t e;
    chk("ov32_occ", 72'(ov32), 72'(q.size() != 0));
    chk("ov64_occ", 72'(ov64), 72'(q.size() != 0));
    chk("cnt32", 72'(cnt32), 72'(mcnt));
    chk("cnt64", 72'(cnt64), 72'(mcnt));
    if (!ov32) chk("idle32_zero", 72'({imm32, fmt32, ill32}), 72'(0));
    if (!ov64) chk("idle64_zero", 72'({imm64, fmt64, ill64}), 72'(0));
    if (stall_prev && ov32) chk("stall_stable", 72'({imm32, fmt32, ill32}), 72'(prev32));
    if (ov32 && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 72'(1), 72'(0));
      end else begin
        e = q.pop_front();
        chk("out32", 72'({imm32, fmt32, ill32}), 72'({e.imm32, e.fmt, e.ill}));
        chk("out64", {4'b0, imm64, fmt64, ill64}, {4'b0, e.imm64, e.fmt, e.ill});
      end
    end
    stall_prev = ov32 && !out_ready;
    prev32     = {imm32, fmt32, ill32};
    if (in_valid && rdy32) begin
      e = exp_of(instruction);
      q.push_back(e);
      if (e.ill && mcnt < 15) mcnt++;
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] ins, input logic ordy);
    @(negedge clk);
    in_valid    = iv;
    instruction = ins;
    out_ready   = ordy;
    #1;
    sample();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 20) begin
      step(1'b0, 32'h0, 1'b1);
      k++;
    end
    chk("drain_timeout", 72'(q.size()), 72'(0));
  endtask

  initial begin
    tbl = '{32'hFFC52283, 32'hFE000EE3, 32'h7FFFF06F, 32'h8000006F,
            32'h00311093, 32'h0230D093, 32'h123450B7, 32'h800000B7,
            32'h00001017, 32'hFE552C23, 32'h00B50533, 32'hFFF00067,
            32'h00000073, 32'h0000007F};
    rst_n = 1'b0; in_valid = 1'b0; instruction = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 72'({rdy32, rdy64}), 72'(0));
    chk("rst_out_valid", 72'({ov32, ov64}), 72'(0));
    chk("rst_outputs", 72'({imm32, fmt32, ill32, cnt32}), 72'(0));
    @(negedge clk); rst_n = 1'b1; #1;
    chk("post_rst_ready", 72'({rdy32, rdy64}), 72'(2'b11));

    // single lw, then idle
    step(1'b1, 32'hFFC52283, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // beq then jal back-to-back
    step(1'b1, 32'hFE000EE3, 1'b1);
    step(1'b1, 32'h7FFFF06F, 1'b1);
    drain();

    // backpressure: three pushes with out_ready low, third refused
    step(1'b1, 32'h00311093, 1'b0);
    step(1'b1, 32'h123450B7, 1'b0);
    step(1'b1, 32'hFE552C23, 1'b0);
    chk("full_in_ready", 72'({rdy32, rdy64}), 72'(0));
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    drain();

    // remaining formats at full rate
    for (int i = 0; i < 14; i++) step(1'b1, tbl[i], 1'b1);
    drain();

    // 17 illegal pushes: counter saturates at 15
    for (int i = 0; i < 17; i++) step(1'b1, 32'h0000007F, 1'b1);
    drain();
    chk("cnt_sat", 72'({cnt32, cnt64}), 72'(8'hFF));

    // randomized handshakes across the table
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), tbl[$urandom_range(0, 13)], ($urandom_range(0, 3) != 0));
    drain();

    // fill both entries, then reset mid-cycle
    step(1'b1, 32'h0000007F, 1'b0);
    step(1'b1, 32'hFFF00067, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("pre_rst_full", 72'(q.size()), 72'(2));
    #2 rst_n = 1'b0; #1;
    chk("midrst_out_valid", 72'({ov32, ov64}), 72'(0));
    chk("midrst_cnt", 72'({cnt32, cnt64}), 72'(0));
    q.delete(); mcnt = 0; stall_prev = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h00001017, 1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 or 64.
REQ-002 SHALL have parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  instruction word valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an instruction this cycle.
REQ-007 SHALL have port instruction  input  32  RV32 instruction word.
REQ-008 SHALL have port out_valid  output  1  ImmExt/fmt/illegal valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts output this cycle.
REQ-010 SHALL have port ImmExt  output  XLEN  sign- or zero-extended immediate.
REQ-011 SHALL have port fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6.
REQ-012 SHALL have port illegal  output  1  opcode not recognised.
REQ-013 SHALL have port illegal_cnt  output  CNT_W  count of illegal instructions accepted.

Function
REQ-014 Decode by instruction[6:0]: 0000011/0010011/1100111/1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011 -> R.
REQ-015 I: sext(instr[31:20]); S: sext({instr[31:25],instr[11:7]}); B: sext({instr[31],instr[7],instr[30:25],instr[11:8],0}).
REQ-016 U: sext({instr[31:12],12'b0}); J: sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); all sign extension to XLEN from instr[31].
REQ-017 Opcode 0010011 with funct3 001 or 101 -> fmt SHAMT, ImmExt zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64).
REQ-018 R format and unrecognised opcodes -> ImmExt all zeros; unrecognised additionally -> fmt R, illegal=1.
REQ-019 Results held in a 2-entry FIFO (skid buffer); push on in_valid&&in_ready, pop on out_valid&&out_ready.
REQ-020 in_ready = (occupancy < 2), combinational from registered state only (no path from out_ready).
REQ-021 out_valid = (occupancy > 0); ImmExt/fmt/illegal driven from head entry; minimum latency 1 cycle, push to out_valid.
REQ-022 While out_valid && !out_ready, ImmExt/fmt/illegal SHALL remain stable.
REQ-023 Simultaneous push and pop: occupancy unchanged; with occupancy 2, push not possible (in_ready=0) that cycle, even if pop occurs.
REQ-024 Full throughput: with out_ready held 1 and occupancy <=1, one instruction accepted per cycle.
REQ-025 Read/write pointers 1 bit each, wrap 1->0; occupancy 2 bits, values 0..2 only.
REQ-026 illegal_cnt increments by 1 on each push with illegal decode; saturates at all-ones, never wraps.
REQ-027 Outputs when out_valid=0: ImmExt, fmt, illegal SHALL be 0.

Reset
REQ-028 rst_n low: occupancy 0, pointers 0, illegal_cnt 0, out_valid 0, in_ready 0 while asserted, ImmExt/fmt/illegal 0.
REQ-029 Reset asserted mid-operation discards all buffered entries immediately (asynchronous); no output after release until a new push.
REQ-030 First push possible on the first rising edge after rst_n deasserts (in_ready=1 then).

Structure
REQ-031 Package imm_pkg SHALL hold opcode constants, fmt encodings, and FIFO depth constant 2.
REQ-032 Combinational decode SHALL be sub-module imm_decode (instruction, XLEN -> ImmExt, fmt, illegal); imm_gen_pipe instantiates it once at input.

Verification
REQ-033 lw 0xFFC52283 (imm -4), out_ready=1 -> next cycle out_valid=1, ImmExt=0xFFFFFFFC, fmt=1, illegal=0.
REQ-034 beq 0xFE000EE3 (imm -4) then jal 0x7FFFF06F, XLEN=64 -> ImmExt 0xFFFFFFFFFFFFFFFC fmt 3, then 0x00000000000FFFFE fmt 5.
REQ-035 out_ready=0, push 3 back-to-back: first two accepted, in_ready=0 on 3rd; outputs stable; release out_ready -> both drain in order.
REQ-036 slli 0x00311093 -> fmt 6, ImmExt=3; lui 0x123450B7 -> ImmExt=0x12345000, fmt 4.
REQ-037 Opcode 0x7F pushed 2^CNT_W+1 times (CNT_W=4, 17 pushes) -> illegal=1, ImmExt=0, illegal_cnt saturates at 15.
REQ-038 rst_n low with 2 entries buffered -> out_valid=0, illegal_cnt=0 same cycle; after release no stale output.
